// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core: fetch FSM state encoding
// and the bubble instruction placed into the IF/ID register.
package mips_pkg;

   // Fetch-stage FSM states.
   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      HELD  = 2'd2
   } fetch_state_e;

   // sll $0,$0,0 encodes as all zeros and is used as the pipeline bubble.
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_stage_add4.sv
// PC incrementer for the fetch stage. Wraps modulo 2^32; no alignment check.
module add4 (
   input  logic [31:0] a,
   output logic [31:0] y
);

   // Plain 32-bit add of the instruction size; carry out is discarded.
   always_comb begin
      y = a + 32'd4;
   end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage plus IF/ID pipeline register. Issues requests to a
// variable-latency instruction memory, buffers a response that arrives while
// the stage is stalled, and drops responses made stale by a branch redirect.
module if_fetch_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        StallF,
   input  logic        StallD,
   input  logic        PCSrcD,
   input  logic [31:0] PCBranchD,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_valid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] PCF,
   output logic [31:0] InstrD,
   output logic [31:0] PCPlus4D,
   output logic        ValidD
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q;
   logic [31:0]  buf_q, buf_d;
   logic         drop_q, drop_d;
   logic         req_q;
   logic [31:0]  instrD_q;
   logic [31:0]  pcPlus4D_q;
   logic         validD_q;

   logic [31:0]  pcPlus4F;
   logic         redirect;
   logic         deliver;
   logic [31:0]  deliverInstr;

   add4 u_add4 (
      .a (pc_q),
      .y (pcPlus4F)
   );

   // A decode-stage branch only counts when decode is not itself stalled,
   // because a stalled decode stage may still be showing a stale branch.
   always_comb begin
      redirect = PCSrcD & ~StallD;
   end

   // Next-state logic for the fetch FSM. Decides whether an instruction is
   // handed to IF/ID this cycle (from memory or from the stall buffer),
   // whether a response must be buffered, and whether an outstanding
   // response has become stale and must be dropped when it finally arrives.
   always_comb begin
      state_d      = state_q;
      buf_d        = buf_q;
      drop_d       = drop_q;
      deliver      = 1'b0;
      deliverInstr = imem_rdata;
      case (state_q)
         FETCH, WAIT: begin
            if (imem_valid) begin
               deliver = ~drop_q & ~StallF;
               if (drop_q) begin
                  drop_d  = 1'b0;
                  state_d = FETCH;
               end else if (redirect) begin
                  state_d = FETCH;
               end else if (StallF) begin
                  buf_d   = imem_rdata;
                  state_d = HELD;
               end else begin
                  state_d = FETCH;
               end
            end else begin
               state_d = WAIT;
               if (redirect) begin
                  drop_d = 1'b1;
               end
            end
         end
         HELD: begin
            deliver      = ~StallF;
            deliverInstr = buf_q;
            if (redirect || !StallF) begin
               state_d = FETCH;
            end
         end
         default: begin
            state_d = FETCH;
         end
      endcase
   end

   // All fetch-stage state: PC, FSM, stall buffer, drop flag, the registered
   // request strobe, and the IF/ID register. Redirect outranks everything so
   // a taken branch loads its target even while fetch is stalled, and the
   // IF/ID register holds its contents completely while decode is stalled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q       <= RESET_PC;
         state_q    <= FETCH;
         buf_q      <= 32'h0000_0000;
         drop_q     <= 1'b0;
         req_q      <= 1'b1;
         instrD_q   <= NOP_INSTR;
         pcPlus4D_q <= 32'h0000_0000;
         validD_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         drop_q  <= drop_d;
         req_q   <= (state_d != HELD);

         if (redirect) begin
            pc_q <= PCBranchD;
         end else if (deliver) begin
            pc_q <= pcPlus4F;
         end

         if (!StallD) begin
            if (!redirect && deliver) begin
               instrD_q   <= deliverInstr;
               pcPlus4D_q <= pcPlus4F;
               validD_q   <= 1'b1;
            end else begin
               instrD_q <= NOP_INSTR;
               validD_q <= 1'b0;
            end
         end
      end
   end

   // Drive the outputs straight from registers.
   always_comb begin
      imem_req  = req_q;
      imem_addr = pc_q;
      PCF       = pc_q;
      InstrD    = instrD_q;
      PCPlus4D  = pcPlus4D_q;
      ValidD    = validD_q;
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a behavioural variable-latency
// instruction memory whose wait-cycle count can be changed between tests.
module tb_if_fetch_stage;

   logic        clk;
   logic        reset;
   logic        StallF;
   logic        StallD;
   logic        PCSrcD;
   logic [31:0] PCBranchD;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_valid;
   logic [31:0] imem_rdata;
   logic [31:0] PCF;
   logic [31:0] InstrD;
   logic [31:0] PCPlus4D;
   logic        ValidD;

   int          vectors;
   int          miscompares;
   int          memWait;
   int          memCnt;
   logic [31:0] heldAddr;
   int          pulses;

   if_fetch_stage dut (
      .clk        (clk),
      .reset      (reset),
      .StallF     (StallF),
      .StallD     (StallD),
      .PCSrcD     (PCSrcD),
      .PCBranchD  (PCBranchD),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_valid (imem_valid),
      .imem_rdata (imem_rdata),
      .PCF        (PCF),
      .InstrD     (InstrD),
      .PCPlus4D   (PCPlus4D),
      .ValidD     (ValidD)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory contents: a fixed scramble of the address so every word differs.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   // Memory response: valid once the request has waited memWait cycles,
   // returning the word for the address captured when the request started.
   always_comb begin
      imem_valid = imem_req && (memCnt >= memWait);
      imem_rdata = memWord((memCnt == 0) ? imem_addr : heldAddr);
   end

   // Memory wait counter; restarts after each accepted response.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         memCnt   <= 0;
         heldAddr <= 32'h0;
      end else if (imem_req) begin
         if (imem_valid) begin
            memCnt <= 0;
         end else begin
            memCnt <= memCnt + 1;
            if (memCnt == 0) heldAddr <= imem_addr;
         end
      end
   end

   // Advance one clock and settle away from the edge.
   task automatic applyStimulus(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Watchdog so the run can never hang.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      memWait     = 3;
      reset       = 1'b1;
      StallF      = 1'b0;
      StallD      = 1'b0;
      PCSrcD      = 1'b0;
      PCBranchD   = 32'h0;
      applyStimulus(2);
      reset = 1'b0;

      // Test 1: reset asserted while waiting on a slow memory.
      applyStimulus(2);
      checkOutput("t1_pre_state_wait", {31'd0, (memCnt == 2)}, 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("t1_async_pcf", PCF, 32'h0);
      applyStimulus(1);
      memWait = 0;
      reset   = 1'b0;
      checkOutput("t1_pcf", PCF, 32'h0);
      checkOutput("t1_validd", {31'd0, ValidD}, 32'd0);
      checkOutput("t1_req", {31'd0, imem_req}, 32'd1);

      // Test 2: zero-wait stream from PC 0.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1);
         checkOutput("t2_instrd", InstrD, memWord(32'(i * 4)));
         checkOutput("t2_pcplus4d", PCPlus4D, 32'(i * 4 + 4));
         checkOutput("t2_validd", {31'd0, ValidD}, 32'd1);
      end

      // Test 3: three wait cycles per access.
      memWait = 3;
      for (int i = 0; i < 4; i++) begin
         checkOutput("t3_addr_stable", imem_addr, 32'd12);
         applyStimulus(1);
         if (i < 3) checkOutput("t3_bubble", {31'd0, ValidD}, 32'd0);
      end
      checkOutput("t3_validd", {31'd0, ValidD}, 32'd1);
      checkOutput("t3_instrd", InstrD, memWord(32'd12));
      checkOutput("t3_pcplus4d", PCPlus4D, 32'd16);
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1);
         if (ValidD) pulses++;
      end
      checkOutput("t3_one_pulse", 32'(pulses), 32'd1);
      checkOutput("t3_instrd2", InstrD, memWord(32'd16));
      checkOutput("t3_pcf", PCF, 32'd20);

      // Test 4: fetch and decode stalled for two cycles with data arriving.
      memWait = 0;
      StallF  = 1'b1;
      StallD  = 1'b1;
      applyStimulus(1);
      checkOutput("t4_req_held", {31'd0, imem_req}, 32'd0);
      checkOutput("t4_instrd_hold1", InstrD, memWord(32'd16));
      applyStimulus(1);
      checkOutput("t4_instrd_hold2", InstrD, memWord(32'd16));
      checkOutput("t4_pcf_hold", PCF, 32'd20);
      StallF = 1'b0;
      StallD = 1'b0;
      applyStimulus(1);
      checkOutput("t4_buf_instrd", InstrD, memWord(32'd20));
      checkOutput("t4_buf_pcplus4d", PCPlus4D, 32'd24);
      checkOutput("t4_buf_validd", {31'd0, ValidD}, 32'd1);
      applyStimulus(1);
      checkOutput("t4_next_instrd", InstrD, memWord(32'd24));
      checkOutput("t4_next_pcplus4d", PCPlus4D, 32'd28);

      // Test 5: branch redirect while a slow access is outstanding.
      memWait = 2;
      applyStimulus(1);
      PCSrcD    = 1'b1;
      PCBranchD = 32'h100;
      applyStimulus(1);
      PCSrcD = 1'b0;
      checkOutput("t5_pcf", PCF, 32'h100);
      checkOutput("t5_addr", imem_addr, 32'h100);
      checkOutput("t5_bubble_valid", {31'd0, ValidD}, 32'd0);
      checkOutput("t5_bubble_instr", InstrD, 32'h0);
      applyStimulus(1);
      checkOutput("t5_dropped", {31'd0, ValidD}, 32'd0);
      checkOutput("t5_addr_after", imem_addr, 32'h100);
      applyStimulus(3);
      checkOutput("t5_target_instr", InstrD, memWord(32'h100));
      checkOutput("t5_target_pc4", PCPlus4D, 32'h104);

      // Test 6: address wrap and a branch ignored under decode stall.
      memWait   = 0;
      PCSrcD    = 1'b1;
      PCBranchD = 32'hFFFF_FFFC;
      applyStimulus(1);
      PCSrcD = 1'b0;
      checkOutput("t6_pcf_top", PCF, 32'hFFFF_FFFC);
      checkOutput("t6_redirect_bubble", {31'd0, ValidD}, 32'd0);
      applyStimulus(1);
      checkOutput("t6_instrd", InstrD, memWord(32'hFFFF_FFFC));
      checkOutput("t6_pcplus4d_wrap", PCPlus4D, 32'h0);
      checkOutput("t6_pcf_wrap", PCF, 32'h0);
      StallF    = 1'b1;
      StallD    = 1'b1;
      PCSrcD    = 1'b1;
      PCBranchD = 32'h200;
      applyStimulus(1);
      checkOutput("t6_ignored_pcf", PCF, 32'h0);
      checkOutput("t6_ignored_instrd", InstrD, memWord(32'hFFFF_FFFC));
      StallF = 1'b0;
      StallD = 1'b0;
      PCSrcD = 1'b0;
      applyStimulus(1);
      checkOutput("t6_resume_instrd", InstrD, memWord(32'h0));
      checkOutput("t6_resume_pcplus4d", PCPlus4D, 32'h4);
      checkOutput("t6_resume_pcf", PCF, 32'h4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
